pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares one physical-memory port between the instruction cache and the data cache in the split-cache LC-3b memory hierarchy.
- Each cache's miss/writeback side (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_resp) connects to one requester port.
- Round-robin arbiter with a latched command register and a 3-state FSM; exactly one line transfer is outstanding at a time.

Parameters:
- FIRST_GRANT, 0, requester that wins the first tie after reset (0 = icache, 1 = dcache).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line-read request
- i_write  in  1  icache line-write request (normally 0)
- i_address  in  16  icache line address (lc3b_word)
- i_wdata  in  128  icache write line (lc3b_line)
- i_rdata  out  128  line returned to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line-read request
- d_write  in  1  dcache line-write (writeback) request
- d_address  in  16  dcache line address
- d_wdata  in  128  dcache write line
- d_rdata  out  128  line returned to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_read  out  1  read command to physical memory
- mem_write  out  1  write command to physical memory
- mem_address  out  16  latched command address
- mem_wdata  out  128  latched write line
- mem_rdata  in  128  line from physical memory
- mem_resp  in  1  physical memory completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_read, mem_write, i_resp and d_resp all 0; mem_address=0; mem_wdata=0; last_grant=~FIRST_GRANT. No memory command in flight after release.
- Requester "i" is pending when i_read|i_write; same rule for "d".
- States: IDLE, BUSY, DONE.
- IDLE:
  - No requester pending: stay in IDLE.
  - Exactly one pending: grant it.
  - Both pending: grant the one that is not last_grant (round robin).
  - On grant: latch address and wdata. Latch mem_write=req_write and mem_read=req_read&~req_write (write wins if both are asserted). Set last_grant and grant_id. Go to BUSY.
- BUSY:
  - mem_read/mem_write/mem_address/mem_wdata are held constant from the latched registers. Requester inputs are ignored.
  - On mem_resp=1: register mem_rdata into the granted side's rdata register. Pulse that side's resp for exactly the next cycle. Clear mem_read/mem_write. Go to DONE.
- DONE: the resp pulse is visible; ungranted resp stays 0. Go to IDLE unconditionally. This bubble lets the requester's controller drop its request before re-arbitration, so a stale request is never re-granted.
- Latency: request seen in cycle N; mem command registered at N+1; mem_resp at cycle M gives requester resp at M+1. Minimum requester turnaround is memory latency +2 cycles. Back-to-back grants are at least 3 cycles apart.
- Fairness: with both sides continuously requesting, grants alternate I,D,I,D. Neither side waits more than one other transfer.
- Request withdrawn during BUSY: the transfer still completes. The resp pulse is still issued; the requester ignores it.
- mem_resp while in IDLE or DONE: ignored, no state change.
- i_rdata/d_rdata hold their last value until overwritten. Only the granted side's register updates.
- Reset mid-transfer: FSM returns to IDLE immediately and mem commands drop the same cycle. Memory is assumed reset by the same rst_n.

Decomposition:
- lc3b_types package: existing lc3b_word and lc3b_line; add an enum pmem_arb_state_t {IDLE, BUSY, DONE} and a requester-id typedef (1 bit, ARB_I=0, ARB_D=1).
- One natural sub-module: arb_rr2. A 2-way round-robin pick from (req_i, req_d, last_grant) to a grant id; purely combinational. All state stays in pmem_arbiter.

Test Plan:
- Single icache read: i_read=1, i_address=0x1230; memory responds after 3 cycles with line 0xA5..A5 -> mem_read=1 and mem_address=0x1230 from cycle 1; i_resp one cycle, i_rdata=0xA5..A5; d_resp stays 0.
- Simultaneous requests after reset, FIRST_GRANT=0: i_read@0x0040 and d_write@0x8000 with d_wdata=0x1111.. -> icache served first. Then mem_write=1, mem_address=0x8000, mem_wdata=0x1111.. is issued; d_resp follows.
- Continuous contention, 6 transfers -> grant order I,D,I,D,I,D; every resp pulse is exactly 1 cycle.
- d_read and d_write both high, address 0x2000 -> mem_write=1, mem_read=0.
- Icache drops i_read in the BUSY cycle after the grant -> mem_read stays high until mem_resp; i_resp still pulses; next state is IDLE with no new grant.
- rst_n low 2 cycles into BUSY -> mem_read=0 asynchronously. After release a new d_read is granted normally, and the stale mem_resp arriving in IDLE is ignored.

Source files
------------

// File: rtl/lc3b_types.sv
// ============================================================================
// Module   : lc3b_types
// Brief    : Shared LC-3b memory-hierarchy types and arbiter enums.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pmem_arb_state_t;

  typedef logic arb_id_t;
  localparam arb_id_t ARB_I = 1'b0;
  localparam arb_id_t ARB_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
// Module   : arb_rr2
// Brief    : Two-way round-robin pick between icache and dcache requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_rr2
  import lc3b_types::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  arb_id_t last_grant,
  output arb_id_t grant
);

  always_comb begin
    grant = ARB_I;
    if (req_i && req_d) begin
      grant = ~last_grant;
    end else if (req_d) begin
      grant = ARB_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// ============================================================================
// Module   : pmem_arbiter
// Brief    : Shares one physical-memory port between icache and dcache.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pmem_arbiter
  import lc3b_types::*;
#(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  output lc3b_line i_rdata,
  output logic     i_resp,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output lc3b_line d_rdata,
  output logic     d_resp,
  output logic     mem_read,
  output logic     mem_write,
  output lc3b_word mem_address,
  output lc3b_line mem_wdata,
  input  lc3b_line mem_rdata,
  input  logic     mem_resp
);

  pmem_arb_state_t r_state, w_next_state;
  arb_id_t  r_last_grant, r_grant_id, w_pick;
  logic     r_mem_read, r_mem_write, r_i_resp, r_d_resp;
  lc3b_word r_mem_address;
  lc3b_line r_mem_wdata, r_i_rdata, r_d_rdata;

  logic w_req_i, w_req_d, w_any_req, w_req_read, w_req_write;

  assign w_req_i   = i_read | i_write;
  assign w_req_d   = d_read | d_write;
  assign w_any_req = w_req_i | w_req_d;

  arb_rr2 u_arb_rr2 (
    .req_i      (w_req_i),
    .req_d      (w_req_d),
    .last_grant (r_last_grant),
    .grant      (w_pick)
  );

  assign w_req_read  = (w_pick == ARB_D) ? d_read  : i_read;
  assign w_req_write = (w_pick == ARB_D) ? d_write : i_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = BUSY;
      BUSY:    if (mem_resp)  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command and response registers; resp pulses last exactly one cycle (DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_resp      <= 1'b0;
      r_d_resp      <= 1'b0;
      r_last_grant  <= arb_id_t'(~FIRST_GRANT);
      r_grant_id    <= ARB_I;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id    <= w_pick;
            r_last_grant  <= w_pick;
            r_mem_address <= (w_pick == ARB_D) ? d_address : i_address;
            r_mem_wdata   <= (w_pick == ARB_D) ? d_wdata   : i_wdata;
            r_mem_write   <= w_req_write;
            r_mem_read    <= w_req_read & ~w_req_write;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_grant_id == ARB_D) begin
              r_d_rdata <= mem_rdata;
              r_d_resp  <= 1'b1;
            end else begin
              r_i_rdata <= mem_rdata;
              r_i_resp  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign i_resp      = r_i_resp;
  assign d_resp      = r_d_resp;

endmodule

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// ============================================================================
// Module   : tb_pmem_arbiter
// Brief    : Directed self-checking bench for pmem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata;
  logic [127:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp;

  int n_cmp  = 0;
  int n_fail = 0;

  pmem_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle memory completion; returns #1 after the edge, in DONE.
  task automatic respond(input logic [127:0] line);
    mem_resp  = 1'b1;
    mem_rdata = line;
    tick();
    mem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [127:0] line_a5, line_11, line_c3, line_5a, line_77;
  logic         exp_d;

  initial begin
    line_a5 = {16{8'hA5}};
    line_11 = {8{16'h1111}};
    line_c3 = {16{8'hC3}};
    line_5a = {16{8'h5A}};
    line_77 = {16{8'h77}};
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    rst_n = 1'b0;
    #2;

    // Reset state
    chk("rst_mem_read",  mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr",  mem_address, 16'h0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_resp",    i_resp, 1'b0);
    chk("rst_d_resp",    d_resp, 1'b0);
    do_reset();

    // Single icache read, memory answers in third BUSY cycle
    i_read = 1; i_address = 16'h1230;
    tick();
    chk("t1_mem_read",  mem_read, 1'b1);
    chk("t1_mem_write", mem_write, 1'b0);
    chk("t1_mem_addr",  mem_address, 16'h1230);
    tick();
    chk("t1_hold_read", mem_read, 1'b1);
    tick();
    respond(line_a5);
    chk("t1_i_resp",    i_resp, 1'b1);
    chk("t1_d_resp",    d_resp, 1'b0);
    chk("t1_i_rdata",   i_rdata, line_a5);
    chk("t1_read_clr",  mem_read, 1'b0);
    i_read = 0;
    tick();
    chk("t1_i_resp_end", i_resp, 1'b0);

    // Simultaneous requests after reset: icache first, then dcache write
    do_reset();
    i_read = 1; i_address = 16'h0040;
    d_write = 1; d_address = 16'h8000; d_wdata = line_11;
    tick();
    chk("t2_first_addr", mem_address, 16'h0040);
    chk("t2_first_read", mem_read, 1'b1);
    tick();
    respond(line_c3);
    chk("t2_i_resp", i_resp, 1'b1);
    chk("t2_d_resp0", d_resp, 1'b0);
    i_read = 0;
    tick();
    tick();
    chk("t2_wr",    mem_write, 1'b1);
    chk("t2_rd",    mem_read, 1'b0);
    chk("t2_addr",  mem_address, 16'h8000);
    chk("t2_wdata", mem_wdata, line_11);
    respond(line_77);
    chk("t2_d_resp",  d_resp, 1'b1);
    chk("t2_i_resp0", i_resp, 1'b0);
    chk("t2_d_rdata", d_rdata, line_77);
    chk("t2_i_keep",  i_rdata, line_c3);
    d_write = 0;
    tick();

    // Continuous contention: I,D,I,D,I,D
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    exp_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr%0d_addr", k), mem_address, exp_d ? 16'h0200 : 16'h0100);
      respond(line_5a);
      chk($sformatf("rr%0d_i_resp", k), i_resp, !exp_d);
      chk($sformatf("rr%0d_d_resp", k), d_resp, exp_d);
      tick();
      chk($sformatf("rr%0d_pulse_end", k), i_resp | d_resp, 1'b0);
      exp_d = !exp_d;
    end
    i_read = 0; d_read = 0;
    tick();
    chk("rr_no_grant", mem_read, 1'b0);

    // d_read and d_write together: write wins
    d_read = 1; d_write = 1; d_address = 16'h2000;
    tick();
    chk("t4_wr",   mem_write, 1'b1);
    chk("t4_rd",   mem_read, 1'b0);
    chk("t4_addr", mem_address, 16'h2000);
    respond(line_a5);
    chk("t4_d_resp", d_resp, 1'b1);
    d_read = 0; d_write = 0;
    tick();

    // Request withdrawn during BUSY
    i_read = 1; i_address = 16'h3000;
    tick();
    i_read = 0;
    tick();
    chk("t5_hold_read", mem_read, 1'b1);
    chk("t5_hold_addr", mem_address, 16'h3000);
    respond(line_c3);
    chk("t5_i_resp",  i_resp, 1'b1);
    chk("t5_i_rdata", i_rdata, line_c3);
    tick();
    tick();
    chk("t5_no_regrant_rd", mem_read, 1'b0);
    chk("t5_no_regrant_wr", mem_write, 1'b0);

    // mem_resp in IDLE is ignored
    respond(line_77);
    chk("idle_resp_i",  i_resp, 1'b0);
    chk("idle_resp_d",  d_resp, 1'b0);
    chk("idle_rdata_i", i_rdata, line_c3);

    // Reset mid-transfer, then a fresh dcache read with a stale mem_resp in IDLE
    i_read = 1; i_address = 16'h5550;
    tick();
    tick();
    rst_n = 1'b0;
    i_read = 0;
    #1;
    chk("t6_async_rd", mem_read, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_resp = 1'b1; mem_rdata = line_11;
    d_read = 1; d_address = 16'h4440;
    tick();
    mem_resp = 1'b0;
    chk("t6_stale_d_resp", d_resp, 1'b0);
    chk("t6_stale_i_resp", i_resp, 1'b0);
    chk("t6_rd",   mem_read, 1'b1);
    chk("t6_addr", mem_address, 16'h4440);
    tick();
    chk("t6_still_busy", mem_read, 1'b1);
    respond(line_5a);
    chk("t6_d_resp",  d_resp, 1'b1);
    chk("t6_d_rdata", d_rdata, line_5a);
    d_read = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
